// File: rtl/alu_sequencer.sv
// Multicycle control sequencer for the shared-bus ALU datapath (R0-R7, A, G).
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (illegal opcodes trap into HALT).
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [15:0]      Instr,
    output logic [2:0]       Ulaop,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic [7:0]       Rin,
    output logic [7:0]       Rout,
    output logic             Done,
    output logic             Busy,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Halted
);

    typedef enum logic [2:0] {T0, T1, T2, T3, HALT} step_t;

    step_t            step_q, step_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] opc;
    logic [7:0] rx_oh;
    logic [7:0] ry_oh;
    logic       ir_unused;

    assign opc       = ir_q[15:12];
    assign rx_oh     = 8'b1 << ir_q[11:9];
    assign ry_oh     = 8'b1 << ir_q[8:6];
    assign ir_unused = ^ir_q[5:0];

    // Control outputs are pure decodes of the current step and the latched IR.
    always_comb begin
        Ulaop  = 3'b000;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Rin    = 8'h00;
        Rout   = 8'h00;
        Done   = 1'b0;
        case (step_q)
            T1: begin
                case (opc)
                    4'h0: begin
                        Rout = ry_oh;
                        Rin  = rx_oh;
                        Done = 1'b1;
                    end
                    4'h1: begin
                        DINout = 1'b1;
                        Rin    = rx_oh;
                        Done   = 1'b1;
                    end
                    4'h2, 4'h3, 4'h4, 4'h5: begin
                        Rout = rx_oh;
                        Ain  = 1'b1;
                    end
                    4'h6, 4'h7: begin
                        Rout  = rx_oh;
                        Gin   = 1'b1;
                        Ulaop = {2'b10, opc[0]};
                    end
                    default: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        Done = 1'b0;
`else
                        Done = 1'b1;
`endif
                    end
                endcase
            end
            T2: begin
                if (opc[3:2] == 2'b01 && opc[1]) begin
                    Gout = 1'b1;
                    Rin  = rx_oh;
                    Done = 1'b1;
                end else begin
                    Rout  = ry_oh;
                    Gin   = 1'b1;
                    Ulaop = 3'(opc - 4'd2);
                end
            end
            T3: begin
                Gout = 1'b1;
                Rin  = rx_oh;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy       = (step_q == T1) || (step_q == T2) || (step_q == T3);
    assign InstrCount = cnt_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign Halted     = (step_q == HALT);
`else
    assign Halted     = 1'b0;
`endif

    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        cnt_d  = Done ? cnt_q + CNT_W'(1) : cnt_q;
        case (step_q)
            T0: begin
                if (Run) begin
                    ir_d   = Instr;
                    step_d = T1;
                end
            end
            T1: begin
                if (Done)        step_d = T0;
                else if (opc[3]) step_d = HALT;
                else             step_d = T2;
            end
            T2:      step_d = Done ? T0 : T3;
            T3:      step_d = T0;
            HALT:    step_d = HALT;
            default: step_d = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= 16'h0000;
            cnt_q  <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded random/directed bench for alu_sequencer, built with a 4-bit counter
// so that count wrap-around is exercised throughout the run.
module tb_alu_sequencer;

    localparam int CW = 4;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b1;
    logic          Run    = 1'b0;
    logic [15:0]   Instr  = 16'h0000;
    logic [2:0]    Ulaop;
    logic          Ain, Gin, Gout, DINout, Done, Busy, Halted;
    logic [7:0]    Rin, Rout;
    logic [CW-1:0] InstrCount;

    always #5 Clock = ~Clock;

    alu_sequencer #(.CNT_W(CW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instr(Instr),
        .Ulaop(Ulaop), .Ain(Ain), .Gin(Gin), .Gout(Gout), .DINout(DINout),
        .Rin(Rin), .Rout(Rout), .Done(Done), .Busy(Busy),
        .InstrCount(InstrCount), .Halted(Halted)
    );

    typedef struct packed {
        logic [2:0] op;
        logic       ain, gin, gout, din;
        logic [7:0] rin, rout;
        logic       done, busy, halted;
    } ctl_t;

    typedef struct packed {
        ctl_t          c;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct packed {
        ctl_t c;
        logic to_halt;
    } pstep_t;

    pstep_t pend[$];   // remaining cycles of the instruction the model is executing
    exp_t   expq[$];   // scoreboard: expected output per clock cycle
    int     m_cnt  = 0;
    bit     m_halt = 1'b0;
    int     checks = 0;
    int     passes = 0;
    int     cyc    = 0;

    // Reference: expand an instruction into its per-step control words.
    function automatic void build(input logic [15:0] ins);
        int         opc;
        logic [7:0] x, y;
        pstep_t     s;
        opc = int'(ins[15:12]);
        x   = 8'h01 << ins[11:9];
        y   = 8'h01 << ins[8:6];
        s = '0; s.c.busy = 1'b1;
        if (opc == 0) begin
            s.c.rout = y; s.c.rin = x; s.c.done = 1'b1; pend.push_back(s);
        end else if (opc == 1) begin
            s.c.din = 1'b1; s.c.rin = x; s.c.done = 1'b1; pend.push_back(s);
        end else if (opc >= 2 && opc <= 5) begin
            s.c.rout = x; s.c.ain = 1'b1; pend.push_back(s);
            s = '0; s.c.busy = 1'b1;
            s.c.rout = y; s.c.gin = 1'b1; s.c.op = 3'(opc - 2); pend.push_back(s);
            s = '0; s.c.busy = 1'b1;
            s.c.gout = 1'b1; s.c.rin = x; s.c.done = 1'b1; pend.push_back(s);
        end else if (opc == 6 || opc == 7) begin
            s.c.rout = x; s.c.gin = 1'b1; s.c.op = (opc == 6) ? 3'd4 : 3'd5; pend.push_back(s);
            s = '0; s.c.busy = 1'b1;
            s.c.gout = 1'b1; s.c.rin = x; s.c.done = 1'b1; pend.push_back(s);
        end else if (TRAP) begin
            s.to_halt = 1'b1; pend.push_back(s);
        end else begin
            s.c.done = 1'b1; pend.push_back(s);
        end
    endfunction

    // One clock of stimulus; the model predicts the output for this cycle.
    task automatic cycle(input logic r, input logic [15:0] ins, input logic rstn);
        exp_t   e;
        pstep_t s;
        @(posedge Clock);
        #1;
        Resetn = rstn;
        Run    = r;
        Instr  = ins;
        e = '0;
        if (!rstn) begin
            pend.delete();
            m_cnt  = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            e.c.halted = 1'b1;
            e.cnt      = CW'(m_cnt);
        end else if (pend.size() > 0) begin
            s     = pend.pop_front();
            e.c   = s.c;
            e.cnt = CW'(m_cnt);
            if (s.c.done) m_cnt = (m_cnt + 1) % (1 << CW);
            if (s.to_halt) m_halt = 1'b1;
        end else begin
            e.cnt = CW'(m_cnt);
            if (r) build(ins);
        end
        expq.push_back(e);
    endtask

    always @(negedge Clock) begin
        exp_t e;
        ctl_t act;
        cyc++;
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            act = {Ulaop, Ain, Gin, Gout, DINout, Rin, Rout, Done, Busy, Halted};
            checks++;
            if (act === e.c && InstrCount === e.cnt) passes++;
            else $display("FAIL ctl cyc=%0d got=%h cnt=%0d expected=%h cnt=%0d",
                          cyc, act, InstrCount, e.c, e.cnt);
            checks++;
            if ($countones(Rout) + int'(Gout) + int'(DINout) <= 1) passes++;
            else $display("FAIL bus_sources cyc=%0d Rout=%h Gout=%b DINout=%b required at most one",
                          cyc, Rout, Gout, DINout);
        end
    end

    initial begin
        logic [15:0] ri;
        int          halt_cyc;
        #1 Resetn = 1'b0;
        repeat (3) cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        // add R1,R2 then idle to see the count
        cycle(1'b1, 16'h2280, 1'b1);
        repeat (4) cycle(1'b0, 16'h0000, 1'b1);
        // sub R3,R4
        cycle(1'b1, 16'h3700, 1'b1);
        repeat (4) cycle(1'b0, 16'h0000, 1'b1);
        // mvi R5 back-to-back with inc4 R6 under Run held high
        cycle(1'b1, 16'h1A00, 1'b1);
        cycle(1'b1, 16'h6C00, 1'b1);
        cycle(1'b1, 16'h6C00, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        // illegal opcode with Run kept high
        cycle(1'b1, 16'hF000, 1'b1);
        repeat (6) cycle(1'b1, 16'hF000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        // reset during T2 of an add, then a normal instruction
        cycle(1'b1, 16'h2280, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 16'h0A40, 1'b1);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1);
        // sixteen mv instructions wrap the 4-bit counter
        repeat (32) cycle(1'b1, 16'h0040, 1'b1);
        repeat (2) cycle(1'b0, 16'h0000, 1'b1);
        // random traffic, including Run during busy steps and occasional resets
        halt_cyc = 0;
        for (int i = 0; i < 1500; i++) begin
            halt_cyc = m_halt ? halt_cyc + 1 : 0;
            ri = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ri[15] = 1'b0;
            if (halt_cyc > 5 || $urandom_range(0, 79) == 0) begin
                cycle(1'b0, ri, 1'b0);
                halt_cyc = 0;
            end else begin
                cycle($urandom_range(0, 2) != 0, ri, 1'b1);
            end
        end
        repeat (3) @(negedge Clock);
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL drain left=%0d required=0", expq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multicycle control FSM that acts as the initiator for the datapath ALU.
- Latches a 16-bit instruction and sequences register-file read/write enables, A-register and G-register loads, bus-source selection and the 3-bit ALU operation code, one step per clock.
- Sits between the instruction source (Run/Instr handshake) and the shared 16-bit bus datapath (R0-R7, A, G, ALU).

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Run  input  1  request: the instruction on Instr is valid this cycle.
- Instr  input  16  instruction word: [15:12] opcode, [11:9] Rx, [8:6] Ry, [5:0] ignored.
- Ulaop  output  3  ALU op: 000 add, 001 sub, 010 slt, 011 cmp, 100 +4, 101 -4.
- Ain  output  1  load A register from bus.
- Gin  output  1  load G register from ALU result.
- Gout  output  1  drive G onto bus.
- DINout  output  1  drive external DIN onto bus.
- Rin  output  8  one-hot register write enable.
- Rout  output  8  one-hot register bus drive.
- Done  output  1  final step of the current instruction.
- Busy  output  1  high in every state except T0/HALT.
- InstrCount  output  CNT_W  count of instructions that asserted Done.
- Halted  output  1  illegal-opcode trap state (see Optional Feature).

Behaviour:
- Registered state: step register {T0,T1,T2,T3,HALT}, IR[15:0], InstrCount.
- All other outputs are combinational decodes of step and IR.
- Reset (Resetn=0, asynchronous): step=T0, IR=0, InstrCount=0.
- While in reset and in T0, all control outputs are 0 and Ulaop=000.
- T0: if Run=1, IR<=Instr and go to T1; otherwise stay in T0. Instr is sampled only in T0.
- Opcode 0000, mv Rx,Ry: T1: Rout[Ry], Rin[Rx], Done.
- Opcode 0001, mvi Rx: T1: DINout, Rin[Rx], Done.
- Opcodes 0010 add, 0011 sub, 0100 slt, 0101 cmp:
  - T1: Rout[Rx], Ain.
  - T2: Rout[Ry], Gin, Ulaop = 000/001/010/011 respectively.
  - T3: Gout, Rin[Rx], Done.
- Opcodes 0110 inc4, 0111 dec4:
  - T1: Rout[Rx], Gin, Ulaop = 100/101.
  - T2: Gout, Rin[Rx], Done.
- Opcodes 1000-1111 are illegal: handled as defined under Optional Feature.
- Ulaop is 000 in every step where Gin=0.
- Latency, T0 to Done inclusive: mv/mvi 2 cycles; inc4/dec4 3 cycles; ALU-register ops 4 cycles.
- The cycle after Done, step=T0.
- Run held high gives back-to-back instructions with one T0 cycle between Done pulses.
- Run during T1-T3 is ignored; no queuing.
- InstrCount increments on each clock edge where Done=1 and wraps from all-ones to 0.
- Rx=Ry is legal; the one-hot Rout/Rin are then on the same index in different steps.
- At most one bus source (Rout bit, Gout, DINout) is active in any cycle. This is an invariant the bench asserts.
- Reset asserted mid-instruction aborts immediately: no partial Rin pulse after the reset edge, InstrCount=0.

Optional Feature:
- Macro ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in T1 enters HALT.
  - HALT: Halted=1, Done=0, all enables 0.
  - Run is ignored in HALT; only Resetn leaves it.
  - InstrCount does not increment for the trapping instruction.
- Undefined: an illegal opcode is a NOP.
  - T1 asserts Done only, with no enables; InstrCount increments.
  - HALT is unreachable; Halted is tied to 0.

Test Plan:
- Reset, then Run=1 with Instr=16'h2280 (add R1,R2):
  - T1: Rout=8'h02, Ain=1.
  - T2: Rout=8'h04, Gin=1, Ulaop=000.
  - T3: Gout=1, Rin=8'h02, Done=1.
  - Then InstrCount=1.
- Instr=16'h3700 (sub R3,R4): T2 has Ulaop=001, Rout=8'h10; T3 has Rin=8'h08; 4 cycles T0 to Done.
- Instr=16'h1A00 (mvi R5) with Run held high, followed by 16'h6C00 (inc4 R6):
  - First instruction: T1 DINout=1, Rin=8'h20, Done=1.
  - After one T0 cycle: Rout=8'h40, Gin=1, Ulaop=100.
  - Next cycle: Gout=1, Rin=8'h40, Done=1.
  - InstrCount=2.
- Instr=16'hF000:
  - With the macro: Halted=1 and stays 1 through 5 cycles of Run=1; Done never rises; InstrCount unchanged.
  - Without the macro: Done=1 in T1, all enables 0.
- Resetn pulled low during T2 of an add:
  - Same cycle: all outputs 0, step=T0.
  - After release: no Rin pulse; the next Run executes normally.
- CNT_W=4: run 16 mv instructions (16'h0040) -> InstrCount wraps to 0 on the 16th Done.
